// File: rtl/ram_dp_pkg.sv
// Shared types and helpers for the dual-port scratch RAM.
// Holds the init FSM state encoding and the even-parity helper.
package ram_dp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int PAR_MAX_W = 64;

    // Callers zero-extend narrower words; zero bits do not change parity.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ram_dp_init_seq.sv
// Post-reset clear sequencer: walks every address once,
// then holds READY until the next reset.
module ram_dp_init_seq
    import ram_dp_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_addr,
    output logic                  init_done
);

    init_state_e           state_q;
    init_state_e           state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clear_we  = 1'b0;
        init_done = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clear_we = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                init_done = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clear_addr = cnt_q;

endmodule

// File: rtl/ram_dp_param.sv
// True dual-port synchronous RAM, registered read-first outputs.
// Define RAM_DP_PARITY_EN to store and check per-word even parity.
module ram_dp_param
    import ram_dp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic [ADDR_WIDTH-1:0] address_0,
    input  logic [ADDR_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    input  logic                  cs_0,
    input  logic                  cs_1,
    input  logic                  we_0,
    input  logic                  we_1,
    input  logic                  oe_0,
    input  logic                  oe_1,
    output logic [DATA_WIDTH-1:0] rdata_0,
    output logic [DATA_WIDTH-1:0] rdata_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic                  collision,
    output logic                  parity_err_0,
    output logic                  parity_err_1
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef RAM_DP_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;

    function automatic logic [MW-1:0] encode(
        input logic [DATA_WIDTH-1:0] d
    );
        return {even_parity(PAR_MAX_W'(d)), d};
    endfunction
`else
    localparam int MW = DATA_WIDTH;

    function automatic logic [MW-1:0] encode(
        input logic [DATA_WIDTH-1:0] d
    );
        return d;
    endfunction
`endif

    logic [MW-1:0] mem [DEPTH];

    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;

    ram_dp_init_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .clear_we  (clear_we),
        .clear_addr(clear_addr),
        .init_done (init_done)
    );

    logic wr_0;
    logic wr_1;
    logic rd_0;
    logic rd_1;
    logic same_addr;
    logic collide;

    assign wr_0      = init_done & cs_0 & we_0;
    assign wr_1      = init_done & cs_1 & we_1;
    assign rd_0      = init_done & cs_0 & ~we_0;
    assign rd_1      = init_done & cs_1 & ~we_1;
    assign same_addr = (address_0 == address_1);
    assign collide   = wr_0 & wr_1 & same_addr;

    logic [MW-1:0] word_0;
    logic [MW-1:0] word_1;
    logic          perr_0;
    logic          perr_1;

    assign word_0 = mem[address_0];
    assign word_1 = mem[address_1];

`ifdef RAM_DP_PARITY_EN
    assign perr_0 = word_0[MW-1] !=
                    even_parity(PAR_MAX_W'(word_0[DATA_WIDTH-1:0]));
    assign perr_1 = word_1[MW-1] !=
                    even_parity(PAR_MAX_W'(word_1[DATA_WIDTH-1:0]));
`else
    assign perr_0 = 1'b0;
    assign perr_1 = 1'b0;
`endif

    // Array has no reset; port 0 wins a same-address write.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else begin
            if (wr_0) begin
                mem[address_0] <= encode(wdata_0);
            end
            if (wr_1 && !collide) begin
                mem[address_1] <= encode(wdata_1);
            end
        end
    end

    logic [DATA_WIDTH-1:0] rdata_0_q;
    logic [DATA_WIDTH-1:0] rdata_1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_0_q    <= '0;
            rdata_1_q    <= '0;
            rvalid_0     <= 1'b0;
            rvalid_1     <= 1'b0;
            parity_err_0 <= 1'b0;
            parity_err_1 <= 1'b0;
            collision    <= 1'b0;
        end else begin
            rvalid_0     <= rd_0;
            rvalid_1     <= rd_1;
            parity_err_0 <= rd_0 & perr_0;
            parity_err_1 <= rd_1 & perr_1;
            collision    <= collide;
            if (rd_0) begin
                rdata_0_q <= word_0[DATA_WIDTH-1:0];
            end
            if (rd_1) begin
                rdata_1_q <= word_1[DATA_WIDTH-1:0];
            end
        end
    end

    assign rdata_0 = oe_0 ? rdata_0_q : '0;
    assign rdata_1 = oe_1 ? rdata_1_q : '0;

endmodule
